// File: rtl/iob_eth_csr_rsp.sv
// Bank of independent read-only CSR response channels: each channel captures its
// source value on request, holds it until consumed, and can clear or wait on the source.
module iob_eth_csr_rsp #(
    parameter int              NCH       = 5,
    parameter int              DATA_W    = 32,
    parameter logic [NCH-1:0]  CLR_MASK  = {NCH{1'b0}},
    parameter logic [NCH-1:0]  WAIT_MASK = {NCH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic [NCH-1:0]        valid_i,
    output logic [NCH-1:0]        ready_o,
    output logic [NCH-1:0]        rvalid_o,
    input  logic [NCH-1:0]        rready_i,
    input  logic [NCH*DATA_W-1:0] value_i,
    output logic [NCH*DATA_W-1:0] rdata_o,
    input  logic [NCH-1:0]        busy_i,
    output logic [NCH-1:0]        clr_o,
    output logic [NCH-1:0]        overrun_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_t;

    state_t                state_r     [NCH];
    state_t                state_nxt_s [NCH];
    logic [NCH-1:0]        ready_s;
    logic [NCH-1:0]        accept_s;
    logic [NCH-1:0]        clr_s;
    logic [NCH-1:0]        overrun_set_s;
    logic [NCH-1:0]        rvalid_s;
    logic [NCH-1:0]        overrun_r;
    logic [NCH*DATA_W-1:0] rdata_r;

    // Per-channel handshake decode and next-state selection
    always_comb begin
        ready_s       = {NCH{1'b0}};
        accept_s      = {NCH{1'b0}};
        clr_s         = {NCH{1'b0}};
        overrun_set_s = {NCH{1'b0}};
        rvalid_s      = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            state_nxt_s[k] = state_r[k];
            if (rst_i) begin
                ready_s[k] = 1'b0;
            end else begin
                ready_s[k] = (state_r[k] == IDLE) && !(WAIT_MASK[k] && busy_i[k]);
            end
            accept_s[k] = valid_i[k] & ready_s[k];
            // The clear pulse shares the capture cycle, so the pre-clear value is returned
            clr_s[k]    = accept_s[k] & CLR_MASK[k];
            rvalid_s[k] = (state_r[k] == RSP);
            case (state_r[k])
                IDLE: begin
                    if (accept_s[k]) begin
                        state_nxt_s[k] = RSP;
                    end else begin
                        state_nxt_s[k] = IDLE;
                    end
                end
                RSP: begin
                    overrun_set_s[k] = valid_i[k] & ~rready_i[k];
                    if (rready_i[k]) begin
                        state_nxt_s[k] = IDLE;
                    end else begin
                        state_nxt_s[k] = RSP;
                    end
                end
                default: begin
                    state_nxt_s[k] = IDLE;
                end
            endcase
        end
    end

    // State, captured data and sticky overrun; everything frozen while cke_i is low
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                for (int k = 0; k < NCH; k++) begin
                    state_r[k] <= IDLE;
                end
                rdata_r   <= {(NCH*DATA_W){1'b0}};
                overrun_r <= {NCH{1'b0}};
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    state_r[k] <= state_nxt_s[k];
                    if (accept_s[k]) begin
                        rdata_r[k*DATA_W +: DATA_W] <= value_i[k*DATA_W +: DATA_W];
                    end
                end
                overrun_r <= overrun_r | overrun_set_s;
            end
        end
    end

    assign ready_o   = ready_s;
    assign clr_o     = clr_s;
    assign rvalid_o  = rvalid_s;
    assign rdata_o   = rdata_r;
    assign overrun_o = overrun_r;

endmodule

// File: tb/tb_iob_eth_csr_rsp.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model of pending responses per channel.
module tb_iob_eth_csr_rsp;
    localparam int NCH = 5;
    localparam int DW  = 32;
    localparam int TW  = NCH * DW;
    localparam logic [NCH-1:0] CLRM  = 5'b00100;
    localparam logic [NCH-1:0] WAITM = 5'b10000;

    logic          clk = 1'b0;
    logic          cke, rst;
    logic [NCH-1:0] valid, ready, rvalid, rready, busy, clr, overrun;
    logic [TW-1:0]  value, rdata;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: which channels hold an undelivered response, its data, sticky overrun
    logic [NCH-1:0] m_pend;
    logic [TW-1:0]  m_data;
    logic [NCH-1:0] m_ovr;

    iob_eth_csr_rsp #(.NCH(NCH), .DATA_W(DW), .CLR_MASK(CLRM), .WAIT_MASK(WAITM)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .rvalid_o(rvalid), .rready_i(rready), .value_i(value), .rdata_o(rdata),
        .busy_i(busy), .clr_o(clr), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] exp_ready();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++)
            r[k] = !rst && !m_pend[k] && !(WAITM[k] && busy[k]);
        return r;
    endfunction

    // model advance on every enabled edge
    always @(posedge clk) begin
        if (cke) begin
            if (rst) begin
                m_pend = '0; m_data = '0; m_ovr = '0;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (m_pend[k]) begin
                        if (valid[k] && !rready[k]) m_ovr[k] = 1'b1;
                        if (rready[k]) m_pend[k] = 1'b0;
                    end else if (valid[k] && !(WAITM[k] && busy[k])) begin
                        m_pend[k] = 1'b1;
                        m_data[k*DW +: DW] = value[k*DW +: DW];
                    end
                end
            end
        end
    end

    // continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("ready",   TW'(ready),   TW'(exp_ready()));
            check_val("clr",     TW'(clr),     TW'(exp_ready() & valid & CLRM));
            check_val("rvalid",  TW'(rvalid),  TW'(m_pend));
            check_val("rdata",   rdata,        m_data);
            check_val("overrun", TW'(overrun), TW'(m_ovr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setv(input int k, input logic [DW-1:0] v);
        value[k*DW +: DW] = v;
    endtask

    initial begin
        cke = 1'b1; rst = 1'b1; valid = '0; rready = '0; busy = '0; value = '0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_rvalid", TW'(rvalid), '0);
        check_val("rst_rdata", rdata, '0);

        // basic read with 1-cycle latency and 2-cycle spacing
        cyc(1);
        setv(0, 32'h0000_1234); valid[0] = 1'b1; rready[0] = 1'b1;
        @(negedge clk);
        check_val("basic_acc_rvalid", TW'(rvalid[0]), TW'(1'b0));
        cyc(1);
        check_val("basic_rvalid", TW'(rvalid[0]), TW'(1'b1));
        check_val("basic_rdata", TW'(rdata[0 +: DW]), TW'(32'h1234));
        check_val("basic_gap_ready", TW'(ready[0]), TW'(1'b0));
        cyc(1);
        check_val("basic_next_ready", TW'(ready[0]), TW'(1'b1));
        cyc(3);
        valid[0] = 1'b0;
        cyc(2);

        // backpressure on ch1
        setv(1, 32'h0000_00AB); valid[1] = 1'b1; rready[1] = 1'b0;
        cyc(1);
        valid[1] = 1'b0; setv(1, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_rvalid", TW'(rvalid[1]), TW'(1'b1));
            check_val("bp_rdata", TW'(rdata[DW +: DW]), TW'(32'h00AB));
            cyc(1);
        end
        rready[1] = 1'b1;
        @(negedge clk);
        check_val("bp_hold", TW'(rvalid[1]), TW'(1'b1));
        cyc(1);
        check_val("bp_release", TW'(rvalid[1]), TW'(1'b0));
        cyc(1);

        // busy wait on ch4
        busy[4] = 1'b1; valid[4] = 1'b1; rready[4] = 1'b1; setv(4, 32'd57);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("busy_ready", TW'(ready[4]), TW'(1'b0));
            cyc(1);
            setv(4, value[4*DW +: DW] + 32'd1);
        end
        busy[4] = 1'b0;
        @(negedge clk);
        check_val("busy_accept", TW'(ready[4]), TW'(1'b1));
        cyc(1);
        valid[4] = 1'b0;
        check_val("busy_rdata", TW'(rdata[4*DW +: DW]), TW'(32'd60));
        cyc(2);

        // read-to-clear on ch2
        setv(2, 32'd7); valid[2] = 1'b1; rready[2] = 1'b1;
        @(negedge clk);
        check_val("clr_pulse", TW'(clr[2]), TW'(1'b1));
        cyc(1);
        valid[2] = 1'b0; setv(2, 32'd0);
        @(negedge clk);
        check_val("clr_once", TW'(clr[2]), TW'(1'b0));
        check_val("clr_rdata", TW'(rdata[2*DW +: DW]), TW'(32'd7));
        cyc(1);
        setv(2, 32'd3); valid[2] = 1'b1;
        cyc(1);
        valid[2] = 1'b0;
        check_val("clr_next", TW'(rdata[2*DW +: DW]), TW'(32'd3));
        cyc(2);

        // overrun then reset on ch3
        setv(3, 32'h33); valid[3] = 1'b1; rready[3] = 1'b0;
        cyc(2);
        check_val("ovr_set", TW'(overrun[3]), TW'(1'b1));
        valid = '0; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check_val("ovr_rst_rvalid", TW'(rvalid), '0);
        check_val("ovr_rst_ovr", TW'(overrun), '0);
        check_val("ovr_rst_rdata", rdata, '0);
        check_val("ovr_rst_ready", TW'(ready), TW'(5'b11111));
        cyc(1);

        // concurrency
        rready = '1;
        for (int k = 0; k < NCH; k++) setv(k, 32'h111 * k + 32'h1);
        valid = '1;
        cyc(1);
        valid = '0;
        check_val("conc_rvalid", TW'(rvalid), TW'(5'b11111));
        for (int k = 0; k < NCH; k++)
            check_val("conc_rdata", TW'(rdata[k*DW +: DW]), TW'(32'h111 * k + 32'h1));
        cyc(2);

        // clock enable freeze
        cke = 1'b0; valid[0] = 1'b1; setv(0, 32'h55);
        @(negedge clk);
        check_val("cke_ready", TW'(ready[0]), TW'(1'b1));
        cyc(2);
        check_val("cke_frozen", TW'(rvalid[0]), TW'(1'b0));
        cke = 1'b1;
        cyc(1);
        valid[0] = 1'b0;
        check_val("cke_resume", TW'(rvalid[0]), TW'(1'b1));
        cyc(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            valid  = NCH'($urandom);
            rready = NCH'($urandom);
            busy   = NCH'($urandom);
            for (int k = 0; k < NCH; k++) setv(k, $urandom);
            rst = ($urandom_range(0, 49) == 0);
            cke = ($urandom_range(0, 7) != 0);
            cyc(1);
        end
        rst = 1'b0; cke = 1'b1; valid = '0;
        cyc(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
